// File: rtl/tv_sync_decoder_if.sv
// rtl/tv_sync_decoder_if.sv - composite sync input and decoded timing outputs
interface tv_sync_decoder_if;
    logic       tv_sync;
    logic       hs_pulse;
    logic       vs_pulse;
    logic       field;
    logic [8:0] line;
    logic       locked;
    logic       pulse_err;

    modport master (
        output tv_sync,
        input  hs_pulse, vs_pulse, field, line, locked, pulse_err
    );

    modport slave (
        input  tv_sync,
        output hs_pulse, vs_pulse, field, line, locked, pulse_err
    );
endinterface

// File: rtl/tv_sync_decoder.sv
// rtl/tv_sync_decoder.sv - composite sync pulse classifier, line/field tracker (option: TVSYNC_GLITCH_FILTER_EN)
module tv_sync_decoder #(
    parameter int NARROW_MIN = 40,
    parameter int NORMAL_MIN = 86,
    parameter int NORMAL_MAX = 200,
    parameter int BROAD_MIN  = 400
) (
    input  logic              clk24,
    input  logic              reset,
    tv_sync_decoder_if.slave  bus
);
    localparam logic [9:0]  NARROW_W = 10'(NARROW_MIN);
    localparam logic [9:0]  NORMAL_W = 10'(NORMAL_MIN);
    localparam logic [9:0]  NMAX_W   = 10'(NORMAL_MAX);
    localparam logic [9:0]  BROAD_W  = 10'(BROAD_MIN);
    localparam logic [10:0] HALF_LIM = 11'd1152;

    typedef enum logic [2:0] {P_NONE, P_EQ, P_NORM, P_ERR, P_BROAD} pulse_e;

    logic        sync1, sync2, s, s_d;
    logic        fall, rise, timeout;
    logic [9:0]  w;
    logic [10:0] per, per_meas;
    pulse_e      cls, cls_next;
    logic [2:0]  broad_cnt;
    logic [1:0]  ok_cnt;
    logic        half, after_normal;
    logic        hs_r, vs_r, err_r, field_r, locked_r;
    logic [8:0]  line_r;

    // Two-flop synchronizer, preloaded high so reset looks like "no sync tip"
    always_ff @(posedge clk24) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= bus.tv_sync;
            sync2 <= sync1;
        end
    end

`ifdef TVSYNC_GLITCH_FILTER_EN
    logic h1, h2, s_f;

    // Majority of three synchronized samples; shifts both edges by two clocks
    always_ff @(posedge clk24) begin
        if (reset) begin
            h1  <= 1'b1;
            h2  <= 1'b1;
            s_f <= 1'b1;
        end else begin
            h1  <= sync2;
            h2  <= h1;
            s_f <= (sync2 & h1) | (sync2 & h2) | (h1 & h2);
        end
    end
    assign s = s_f;
`else
    assign s = sync2;
`endif

    assign fall    = s_d & ~s;
    assign rise    = ~s_d & s;
    assign timeout = ~fall && (per == 11'd2046);

    // Edge history plus sync-tip width and falling-edge period measurement
    always_ff @(posedge clk24) begin
        if (reset) begin
            s_d      <= 1'b1;
            w        <= '0;
            per      <= '0;
            per_meas <= '0;
        end else begin
            s_d <= s;
            if (fall)
                w <= 10'd1;
            else if (!s && w != 10'h3FF)
                w <= w + 10'd1;
            if (fall) begin
                per_meas <= per;
                per      <= 11'd1;
            end else if (per != 11'h7FF) begin
                per <= per + 11'd1;
            end
        end
    end

    // Classify the finished pulse by its width on the rising edge of s
    always_comb begin
        cls_next = P_NONE;
        if (rise) begin
            if (w < NARROW_W)
                cls_next = P_NONE;
            else if (w < NORMAL_W)
                cls_next = P_EQ;
            else if (w <= NMAX_W)
                cls_next = P_NORM;
            else if (w < BROAD_W)
                cls_next = P_ERR;
            else
                cls_next = P_BROAD;
        end
    end

    // Classification stage; gives the third clock of strobe latency
    always_ff @(posedge clk24) begin
        if (reset)
            cls <= P_NONE;
        else
            cls <= cls_next;
    end

    // Apply a classified pulse to line/field/lock state and issue strobes
    always_ff @(posedge clk24) begin
        if (reset) begin
            hs_r         <= 1'b0;
            vs_r         <= 1'b0;
            err_r        <= 1'b0;
            field_r      <= 1'b0;
            locked_r     <= 1'b0;
            line_r       <= '0;
            broad_cnt    <= '0;
            ok_cnt       <= '0;
            half         <= 1'b0;
            after_normal <= 1'b0;
        end else begin
            hs_r  <= 1'b0;
            vs_r  <= 1'b0;
            err_r <= 1'b0;
            case (cls)
                P_NORM: begin
                    hs_r         <= 1'b1;
                    broad_cnt    <= '0;
                    after_normal <= 1'b1;
                    if (line_r != 9'h1FF)
                        line_r <= line_r + 9'd1;
                end
                P_EQ: begin
                    broad_cnt    <= '0;
                    after_normal <= 1'b0;
                    if (after_normal)
                        half <= (per_meas < HALF_LIM);
                end
                P_ERR: begin
                    err_r        <= 1'b1;
                    broad_cnt    <= '0;
                    after_normal <= 1'b0;
                end
                P_BROAD: begin
                    after_normal <= 1'b0;
                    if (broad_cnt != 3'd7)
                        broad_cnt <= broad_cnt + 3'd1;
                    if (broad_cnt == 3'd2) begin
                        vs_r    <= 1'b1;
                        line_r  <= '0;
                        field_r <= half;
                        if (line_r >= 9'd300 && line_r <= 9'd320) begin
                            if (ok_cnt != 2'd2)
                                ok_cnt <= ok_cnt + 2'd1;
                            if (ok_cnt != 2'd0)
                                locked_r <= 1'b1;
                        end else begin
                            ok_cnt   <= '0;
                            locked_r <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
            if (timeout) begin
                locked_r  <= 1'b0;
                broad_cnt <= '0;
                ok_cnt    <= '0;
            end
        end
    end

    assign bus.hs_pulse  = hs_r;
    assign bus.vs_pulse  = vs_r;
    assign bus.pulse_err = err_r;
    assign bus.field     = field_r;
    assign bus.locked    = locked_r;
    assign bus.line      = line_r;
endmodule

// File: tb/tb_tv_sync_decoder.sv
// tb/tb_tv_sync_decoder.sv - directed vector bench for tv_sync_decoder
module tb_tv_sync_decoder;
`ifdef TVSYNC_GLITCH_FILTER_EN
    localparam int LAT = 5;
    localparam int XTRA = 2;
`else
    localparam int LAT = 3;
    localparam int XTRA = 0;
`endif

    logic clk24 = 1'b0;
    logic reset = 1'b1;
    always #5 clk24 = ~clk24;

    tv_sync_decoder_if bus();
    tv_sync_decoder dut (.clk24(clk24), .reset(reset), .bus(bus));

    int cyc = 0;
    int rise_cyc = 0, fall_cyc = 0;
    int hs_cnt = 0, vs_cnt = 0, err_cnt = 0, both_cnt = 0, hs_lat = 0;
    int n_cmp = 0, n_bad = 0;

    always @(posedge clk24) cyc <= cyc + 1;

    always @(negedge clk24) begin
        if (!reset) begin
            if (bus.hs_pulse) begin
                hs_cnt = hs_cnt + 1;
                hs_lat = cyc - rise_cyc;
            end
            if (bus.vs_pulse) vs_cnt = vs_cnt + 1;
            if (bus.pulse_err) err_cnt = err_cnt + 1;
            if (bus.hs_pulse && bus.vs_pulse) both_cnt = both_cnt + 1;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // called at a negedge; low for lo clocks, then high for hi clocks
    task automatic pulse(input int lo, input int hi);
        bus.tv_sync = 1'b0;
        fall_cyc = cyc + 1;
        repeat (lo) @(negedge clk24);
        bus.tv_sync = 1'b1;
        rise_cyc = cyc + 1;
        repeat (hi) @(negedge clk24);
    endtask

    task automatic broad5(output int vs_at);
        int v0;
        vs_at = 0;
        for (int k = 1; k <= 5; k++) begin
            v0 = vs_cnt;
            pulse(655, 10);
            if (vs_cnt != v0) vs_at = (vs_at == 0 && vs_cnt == v0 + 1) ? k : -1;
        end
    endtask

    task automatic eqs(input int n);
        for (int k = 0; k < n; k++) pulse(56, 10);
    endtask

    task automatic lines(input int n, input int last_period);
        for (int k = 0; k < n; k++) pulse(86, (k == n - 1) ? last_period - 86 : 6);
    endtask

    function automatic int outs_word();
        return {18'd0, bus.locked, bus.field, bus.hs_pulse, bus.vs_pulse, bus.pulse_err, bus.line};
    endfunction

    typedef struct {
        int lo;
        int hi;
        int hs;
        int err;
        int line;
    } vec_t;

    vec_t tbl [19];

    initial begin
        int h0, e0, v0, vs_at;

        tbl[0]  = '{114, 1422, 1, 0, 1};
        tbl[1]  = '{114, 1422, 1, 0, 2};
        tbl[2]  = '{114, 1422, 1, 0, 3};
        tbl[3]  = '{300,  400, 0, 1, 3};
        tbl[4]  = '{114,  400, 1, 0, 4};
        tbl[5]  = '{ 30,  400, 0, 0, 4};
        tbl[6]  = '{ 86,  200, 1, 0, 5};
        tbl[7]  = '{200,  200, 1, 0, 6};
        tbl[8]  = '{201,  200, 0, 1, 6};
        tbl[9]  = '{ 85,  200, 0, 0, 6};
        tbl[10] = '{ 40,  200, 0, 0, 6};
        tbl[11] = '{ 39,  200, 0, 0, 6};
        tbl[12] = '{399,  200, 0, 1, 6};
        tbl[13] = '{400,  200, 0, 0, 6};
        tbl[14] = '{ 86,  200, 1, 0, 7};
        tbl[15] = '{400,  100, 0, 0, 7};
        tbl[16] = '{400,  100, 0, 0, 7};
        tbl[17] = '{ 86,  100, 1, 0, 8};
        tbl[18] = '{ 60,  100, 0, 0, 8};

        bus.tv_sync = 1'b1;
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk24);
            chk($sformatf("reset_outs_%0d", k), outs_word(), 0);
        end
        reset = 1'b0;
        @(negedge clk24);
        chk("post_reset_outs", outs_word(), 0);
        repeat (3) @(negedge clk24);

        for (int i = 0; i < 19; i++) begin
            h0 = hs_cnt; e0 = err_cnt; v0 = vs_cnt;
            pulse(tbl[i].lo, tbl[i].hi);
            chk($sformatf("v%0d_hs", i), hs_cnt - h0, tbl[i].hs);
            chk($sformatf("v%0d_err", i), err_cnt - e0, tbl[i].err);
            chk($sformatf("v%0d_vs", i), vs_cnt - v0, 0);
            chk($sformatf("v%0d_line", i), int'(bus.line), tbl[i].line);
            if (tbl[i].hs != 0) chk($sformatf("v%0d_hs_lat", i), hs_lat, LAT);
        end

        e0 = err_cnt;
        broad5(vs_at);
        chk("f1_vs_at", vs_at, 3);
        chk("f1_line", int'(bus.line), 0);
        chk("f1_locked", int'(bus.locked), 0);
        eqs(5);
        h0 = hs_cnt;
        lines(305, 1536);
        chk("f1_hs_count", hs_cnt - h0, 305);
        chk("f1_line_end", int'(bus.line), 305);
        eqs(7);

        broad5(vs_at);
        chk("f2_vs_at", vs_at, 3);
        chk("f2_line", int'(bus.line), 0);
        chk("f2_field", int'(bus.field), 0);
        chk("f2_locked", int'(bus.locked), 0);
        eqs(5);
        lines(305, 600);
        chk("f2_line_end", int'(bus.line), 305);
        eqs(7);

        broad5(vs_at);
        chk("f3_vs_at", vs_at, 3);
        chk("f3_line", int'(bus.line), 0);
        chk("f3_field", int'(bus.field), 1);
        chk("f3_locked", int'(bus.locked), 1);
        chk("pal_err_count", err_cnt - e0, 0);
        chk("hs_vs_overlap", both_cnt, 0);

        eqs(1);
        lines(3, 92);
        chk("to_line_before", int'(bus.line), 3);
        chk("to_locked_before", int'(bus.locked), 1);
`ifdef TVSYNC_GLITCH_FILTER_EN
        repeat (1000) @(negedge clk24);
        bus.tv_sync = 1'b0;
        @(negedge clk24);
        bus.tv_sync = 1'b1;
`endif
        while (cyc < fall_cyc + 2047 + XTRA) @(negedge clk24);
        chk("to_locked_at_2046", int'(bus.locked), 1);
        @(negedge clk24);
        chk("to_locked_at_2047", int'(bus.locked), 0);
        chk("to_line_hold", int'(bus.line), 3);
        chk("to_field_hold", int'(bus.field), 1);
        repeat (60) @(negedge clk24);
        chk("to_locked_stays", int'(bus.locked), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
